// File: rtl/fake_netlist_misr.sv
// Stream compactor: XOR-folds each IN_W-bit vector to SIG_W bits and feeds a
// SIG_W-bit MISR over a programmed vector count, with a one-cycle done pulse.
module fake_netlist_misr #(
  parameter int               IN_W  = 34,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021,
  parameter logic [SIG_W-1:0] SEED  = 16'hFFFF,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] sig,
  output logic             sig_par
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int NSL   = (IN_W + SIG_W - 1) / SIG_W;
  localparam int PAD_W = NSL * SIG_W;

  state_t             state, state_n;
  logic [PAD_W-1:0]   padded;
  logic [SIG_W-1:0]   fold;
  logic [SIG_W-1:0]   fold_q;
  logic               fold_v;
  logic [CNT_W-1:0]   rem;
  logic               accept;
  logic               load;

  always_comb begin
    padded = PAD_W'(in_data);
    fold   = '0;
    for (int unsigned i = 0; i < NSL; i++) begin
      fold = fold ^ padded[i*SIG_W +: SIG_W];
    end
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && rem == CNT_W'(1)) state_n = DRAIN;
      end
      DRAIN: begin
        busy    = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Stage 1 registers the fold; stage 2 folds it into the MISR a cycle later,
  // which is why the final vector is absorbed during DRAIN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      fold_q <= '0;
      fold_v <= 1'b0;
      rem    <= '0;
      sig    <= '0;
    end else begin
      state  <= state_n;
      fold_v <= accept;
      if (accept) fold_q <= fold;
      if (load) rem <= len;
      else if (accept) rem <= rem - 1'b1;
      if (load) sig <= SEED;
      else if (fold_v)
        sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ fold_q;
    end
  end

  assign sig_par = ^sig;

endmodule

// File: tb/tb_fake_netlist_misr.sv
// Scoreboard bench for fake_netlist_misr: stimulus pushes expected signatures,
// a monitor pops and checks them on each done pulse.
module tb_fake_netlist_misr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [33:0] in_data = '0;
  logic        busy;
  logic        done;
  logic [15:0] sig;
  logic        sig_par;

  fake_netlist_misr #(
    .IN_W (34),
    .SIG_W(16),
    .POLY (16'h1021),
    .SEED (16'hFFFF),
    .CNT_W(16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .len     (len),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .busy    (busy),
    .done    (done),
    .sig     (sig),
    .sig_par (sig_par)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sig;
    int          n;
  } exp_t;

  exp_t        exp_q[$];
  logic [33:0] vec[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          exp_busy = 1'b0;
  bit          chk_rst = 1'b0;
  bit          fin = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: fold bit b of the vector onto bit b mod 16, then multiply the
  // signature by x modulo x^16+x^12+x^5+1 and add the fold.
  function automatic logic [15:0] model(int n);
    logic [16:0] s;
    logic [15:0] f;
    s = 17'h0FFFF;
    for (int k = 0; k < n; k++) begin
      f = '0;
      for (int b = 0; b < 34; b++) f[b % 16] = f[b % 16] ^ vec[k][b];
      s = {s[15:0], 1'b0};
      if (s[16]) s = s ^ 17'h11021;
      s = {1'b0, s[15:0] ^ f};
    end
    return s[15:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: the only process that compares.
  initial begin : monitor
    int   acc;
    int   due;
    exp_t e;
    acc = 0;
    due = -1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc = 0;
      end else begin
        if (start && !busy && !done) begin
          acc = 0;
          if (len == 16'd0) due = cyc + 1;
        end
        if (in_valid && in_ready) begin
          acc++;
          due = cyc + 2;
        end
        if (exp_busy) chk("busy_in_run", 32'(busy), 32'd1);
        if (chk_rst) chk("reset_state", 32'({sig, sig_par, busy, in_ready, done}), 32'd0);
        if (done) begin
          if (exp_q.size() == 0) begin
            chk("done_without_run", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            chk("sig", 32'(sig), 32'(e.sig));
            chk("sig_par", 32'(sig_par), 32'(^e.sig));
            chk("accepts", 32'(acc), 32'(e.n));
            chk("done_latency", 32'(cyc), 32'(due));
          end
        end
      end
      if (fin) begin
        chk("pending_runs", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  end

  task automatic run(input int n, input int gap, input bit noise);
    exp_t e;
    int   w;
    int   g;
    e.sig = model(n);
    e.n   = n;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b1;
    len   = 16'(n);
    if (noise) begin in_valid = 1'b1; in_data = 34'({$urandom, $urandom}); end
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    if (n > 0) exp_busy = 1'b1;
    for (int i = 0; i < n; i++) begin
      g = (i == 0) ? 0 : ((gap < 0) ? int'($urandom_range(0, 3)) : gap);
      repeat (g) begin
        if (noise) begin start = 1'b1; len = 16'($urandom); in_data = 34'({$urandom, $urandom}); end
        @(posedge clk); #1;
        start = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = vec[i];
      w = 0;
      do begin @(negedge clk); w++; end while (!in_ready && w < 20);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    exp_busy = 1'b0;
    if (noise) begin in_valid = 1'b1; in_data = 34'({$urandom, $urandom}); end
    w = 0;
    do begin @(negedge clk); w++; end while (!done && w < 20);
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic set_vecs(input logic [33:0] a, input logic [33:0] b, input int n);
    vec.delete();
    if (n > 0) vec.push_back(a);
    if (n > 1) vec.push_back(b);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_rst = 1'b1;
    @(posedge clk); #1 chk_rst = 1'b0;

    set_vecs('0, '0, 0);              run(0, 0, 1'b0);
    set_vecs(34'h0, '0, 1);           run(1, 0, 1'b0);
    set_vecs(34'h1, '0, 1);           run(1, 0, 1'b0);
    set_vecs(34'h0_0001_0001, '0, 1); run(1, 0, 1'b0);
    set_vecs(34'h3_0000_0000, '0, 1); run(1, 0, 1'b0);
    set_vecs('0, '0, 2);              run(2, 3, 1'b0);
    set_vecs('0, '0, 2);              run(2, 2, 1'b1);

    // Abandon a run after one of three accepts.
    set_vecs(34'h1234, 34'h5678, 2);
    vec.push_back(34'h9abc);
    @(posedge clk); #1;
    start = 1'b1; len = 16'd3;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = vec[0];
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_rst = 1'b1;
    @(posedge clk); #1 chk_rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    set_vecs(34'h0, '0, 1);           run(1, 0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      n = int'($urandom_range(0, 6));
      vec.delete();
      for (int k = 0; k < n; k++) vec.push_back(34'({$urandom, $urandom}));
      run(n, -1, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1 fin = 1'b1;
  end

endmodule
